effect_i2s_tx: RTL and testbench

EFFECT_I2S_TX -- requirements
Module: effect_i2s_tx

---
 rtl/effect_i2s_tx.sv | 76 +++++++
 tb/tb_effect_i2s_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/effect_i2s_tx.sv
// effect_i2s_tx: mono sample handshake into a hold register, serialised as an I2S stereo frame.
module effect_i2s_tx #(
  parameter int data_width = 16,
  parameter int clk_div = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [data_width-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_read_done,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  output logic                  o_underrun
);
  localparam int SW = $clog2(2 * data_width);
  localparam int DW = $clog2(clk_div);
  localparam logic [SW-1:0] S_LAST = SW'(2 * data_width - 1);
  localparam logic [SW-1:0] LR_LO = SW'(data_width - 1);
  localparam logic [SW-1:0] LR_HI = SW'(2 * data_width - 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(clk_div - 1);
  typedef enum logic [1:0] {H_IDLE, H_ACK, H_WAIT_LOW} hs_t;
  hs_t                    hs_q, hs_d;
  logic [data_width-1:0]  hold_q;
  logic                   hold_full_q;
  logic [DW-1:0]          div_q;
  logic [SW-1:0]          s_q, s_d;
  logic [2*data_width-1:0] frame_q;
  logic                   read_done_q, bclk_q, lrclk_q, sdata_q, underrun_q;
  logic                   capture, div_wrap, fall, load;
  always_comb begin
    capture  = (hs_q == H_IDLE) && i_data_valid && !hold_full_q;
    div_wrap = div_q == DIV_LAST;
    fall     = div_wrap && bclk_q;
    s_d      = (s_q == S_LAST) ? '0 : s_q + 1'b1;
    load     = fall && (s_d == '0);
    hs_d     = (hs_q == H_IDLE) ? (capture ? H_ACK : H_IDLE) :
               (hs_q == H_ACK)  ? H_WAIT_LOW :
               (i_data_valid ? H_WAIT_LOW : H_IDLE);
  end
  // a capture landing on the frame load is not an underrun: the old hold value goes out and the new one waits
  always_ff @(posedge clk) begin
    if (!reset) begin
      hs_q        <= H_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      div_q       <= '0;
      s_q         <= S_LAST;
      frame_q     <= '0;
      read_done_q <= 1'b0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hs_q        <= hs_d;
      read_done_q <= hs_d == H_ACK;
      if (capture) hold_q <= i_data;
      hold_full_q <= capture | (hold_full_q & ~load);
      underrun_q  <= underrun_q | (load & ~hold_full_q & ~capture);
      div_q       <= div_wrap ? '0 : div_q + 1'b1;
      if (div_wrap) bclk_q <= ~bclk_q;
      if (fall) begin
        s_q     <= s_d;
        lrclk_q <= (s_d >= LR_LO) && (s_d <= LR_HI);
        sdata_q <= load ? hold_q[data_width-1] : frame_q[2*data_width-2];
        frame_q <= load ? {hold_q, hold_q} : frame_q << 1;
      end
    end
  end
  assign o_read_done = read_done_q;
  assign o_bclk      = bclk_q;
  assign o_lrclk     = lrclk_q;
  assign o_sdata     = sdata_q;
  assign o_underrun  = underrun_q;
endmodule

// File: tb/tb_effect_i2s_tx.sv
// tb_effect_i2s_tx: directed checks of handshake, I2S framing, underrun and reset behaviour.
module tb_effect_i2s_tx;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [W-1:0] i_data = '0;
  logic i_data_valid = 1'b0;
  logic o_read_done, o_bclk, o_lrclk, o_sdata, o_underrun;
  int checks = 0, errors = 0;
  logic [31:0] frames[$];
  int slot = 31, cyc = 0, last_rise = -1, last_lr = -1;
  logic prev_bclk = 1'b0, prev_sd = 1'b0, prev_lr = 1'b0;
  logic [31:0] fbits = '0;
  logic [15:0] vals[4] = '{16'h7fff, 16'h0000, 16'ha5a5, 16'h1357};
  logic [31:0] f;
  effect_i2s_tx #(.data_width(W), .clk_div(4)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_read_done(o_read_done), .o_bclk(o_bclk), .o_lrclk(o_lrclk),
    .o_sdata(o_sdata), .o_underrun(o_underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask
  // reference slot tracker: frames are assembled from o_sdata at each BCLK falling edge
  always @(negedge clk) begin
    if (!reset) begin
      slot = 31; cyc = 0; last_rise = -1; last_lr = -1;
      prev_bclk = 1'b0; prev_sd = 1'b0; prev_lr = 1'b0;
    end else begin
      cyc++;
      if (o_sdata !== prev_sd) chk("sdata_on_fall", {31'b0, prev_bclk & ~o_bclk}, 1);
      if (o_bclk && !prev_bclk) begin
        if (last_rise >= 0) chk("bclk_period", cyc - last_rise, 8);
        last_rise = cyc;
      end
      if (o_lrclk !== prev_lr) begin
        if (last_lr >= 0) chk("lrclk_period", cyc - last_lr, 128);
        last_lr = cyc;
      end
      if (prev_bclk && !o_bclk) begin
        slot = (slot + 1) % 32;
        fbits[31-slot] = o_sdata;
        chk("lrclk_slot", {31'b0, o_lrclk}, {31'b0, slot >= 15 && slot <= 30});
        if (slot == 31) frames.push_back(fbits);
      end
      prev_bclk = o_bclk; prev_sd = o_sdata; prev_lr = o_lrclk;
    end
  end
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    i_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'b0, o_read_done, o_bclk, o_lrclk, o_sdata, o_underrun}, 0);
    frames.delete();
    reset = 1'b1;
  endtask
  task automatic wait_frame(output logic [31:0] fr);
    int n = 0;
    while (frames.size() == 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (frames.size() == 0) begin
      chk("frame_timeout", frames.size(), 1);
      fr = '0;
    end else fr = frames.pop_front();
  endtask
  task automatic wait_ack();
    int n = 0;
    while (!o_read_done && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_seen", {31'b0, o_read_done}, 1);
  endtask
  task automatic wait_slot(input int s);
    int n = 0;
    while (slot != s && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("slot_reach", slot, s);
  endtask
  task automatic send(input logic [15:0] v);
    i_data = v;
    i_data_valid = 1'b1;
    wait_ack();
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'b0, o_read_done}, 0);
    i_data_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  initial begin
    do_reset();
    i_data = 16'h8001;
    i_data_valid = 1'b1;
    @(posedge clk); #1;
    chk("ack_latency", {31'b0, o_read_done}, 1);
    @(posedge clk); #1;
    chk("ack_pulse_end", {31'b0, o_read_done}, 0);
    i_data_valid = 1'b0;
    @(posedge clk); #1;
    foreach (vals[k]) send(vals[k]);
    wait_frame(f);
    chk("basic_frame", f, 32'h8001_8001);
    for (int k = 0; k < 4; k++) begin
      wait_frame(f);
      chk("bp_frame", f, {vals[k], vals[k]});
    end
    chk("bp_no_underrun", {31'b0, o_underrun}, 0);
    wait_frame(f);
    chk("bp_repeat_last", f, {vals[3], vals[3]});
    chk("bp_underrun_set", {31'b0, o_underrun}, 1);
    do_reset();
    send(16'h1234);
    wait_frame(f);
    chk("ur_frame1", f, 32'h1234_1234);
    chk("ur_flag_clear", {31'b0, o_underrun}, 0);
    wait_frame(f);
    chk("ur_frame2", f, 32'h1234_1234);
    chk("ur_flag_set", {31'b0, o_underrun}, 1);
    wait_frame(f);
    chk("ur_frame3", f, 32'h1234_1234);
    chk("ur_flag_sticky", {31'b0, o_underrun}, 1);
    wait_slot(2);
    send(16'hbeef);
    wait_slot(10);
    chk("pre_reset_sdata", {31'b0, o_sdata}, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midframe_reset_outputs", {27'b0, o_read_done, o_bclk, o_lrclk, o_sdata, o_underrun}, 0);
    @(posedge clk); #1;
    frames.delete();
    reset = 1'b1;
    wait_frame(f);
    chk("post_reset_hold_lost", f, 32'h0);
    chk("post_reset_underrun", {31'b0, o_underrun}, 1);
    do_reset();
    send(16'h0f0f);
    wait_frame(f);
    chk("sim_frame1", f, 32'h0f0f_0f0f);
    repeat (6) @(posedge clk);
    #1;
    i_data = 16'hc3c3;
    i_data_valid = 1'b1;
    @(posedge clk); #1;
    chk("sim_ack", {31'b0, o_read_done}, 1);
    @(posedge clk); #1;
    i_data_valid = 1'b0;
    wait_frame(f);
    chk("sim_old_sample", f, 32'h0f0f_0f0f);
    chk("sim_no_underrun", {31'b0, o_underrun}, 0);
    wait_frame(f);
    chk("sim_new_sample", f, 32'hc3c3_c3c3);
    chk("sim_no_underrun2", {31'b0, o_underrun}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
